// File: rtl/shift_reg4_ctrl_if.sv
// Command bus between the command source and shift_reg4_ctrl.
// Carries cmd_valid/cmd_ready handshake plus op, data and count.
interface shift_reg4_ctrl_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [3:0] cmd_data;
   logic [1:0] cmd_count;

   modport master (
      output cmd_valid, cmd_op, cmd_data, cmd_count,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data, cmd_count,
      output cmd_ready
   );
endinterface

// File: rtl/shift_reg4_ctrl.sv
// Sequencer driving a 4-bit shift_reg4: load, clear, shift-in, rotate.
// Ports: clk, reset (async active-low), cmd (slave bus), sr_* pins,
// so_valid/so_bit stream, busy, done pulse, registered result.
module shift_reg4_ctrl (
   input  logic                    clk,
   input  logic                    reset,
   shift_reg4_ctrl_if.slave        cmd,
   output logic                    sr_set,
   output logic [3:0]              sr_d,
   output logic                    sr_sin,
   input  logic [3:0]              sr_q,
   output logic                    so_valid,
   output logic                    so_bit,
   output logic                    busy,
   output logic                    done,
   output logic [3:0]              result
);

   localparam logic [1:0] OP_LOAD   = 2'b00;
   localparam logic [1:0] OP_ROTATE = 2'b10;
   localparam logic [1:0] OP_CLEAR  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] op_q, op_d;
   logic [3:0] data_q, data_d;
   logic [1:0] cnt_q, cnt_d;
   logic [3:0] result_q, result_d;
   logic       done_q, done_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         op_q     <= 2'b00;
         data_q   <= 4'h0;
         cnt_q    <= 2'd0;
         result_q <= 4'h0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         data_q   <= data_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      data_d   = data_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      done_d   = 1'b0;
      sr_set   = 1'b1;
      sr_d     = sr_q;
      sr_sin   = 1'b0;
      so_valid = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (cmd.cmd_valid) begin
               op_d   = cmd.cmd_op;
               data_d = cmd.cmd_data;
               // count 0 wraps to 3, i.e. four shift cycles
               cnt_d  = cmd.cmd_count - 2'd1;
               if (cmd.cmd_op == OP_LOAD || cmd.cmd_op == OP_CLEAR)
                  state_d = S_LOAD;
               else
                  state_d = S_SHIFT;
            end
         end
         S_LOAD: begin
            sr_d     = (op_q == OP_CLEAR) ? 4'h0 : data_q;
            result_d = sr_d;
            done_d   = 1'b1;
            state_d  = S_DONE;
         end
         S_SHIFT: begin
            sr_set   = 1'b0;
            so_valid = 1'b1;
            // data is consumed LSB first by shifting it down each cycle
            sr_sin   = (op_q == OP_ROTATE) ? sr_q[3] : data_q[0];
            data_d   = {1'b0, data_q[3:1]};
            if (cnt_q == 2'd0) begin
               result_d = {sr_q[2:0], sr_sin};
               done_d   = 1'b1;
               state_d  = S_DONE;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign cmd.cmd_ready = (state_q == S_IDLE);
   assign busy          = (state_q != S_IDLE);
   assign so_bit        = sr_q[3];
   assign done          = done_q;
   assign result        = result_q;

endmodule

// File: tb/tb_shift_reg4_ctrl.sv
// Directed bench for shift_reg4_ctrl with a behavioural shift_reg4.
// Results are scoreboarded; pin activity is checked cycle by cycle.
module tb_shift_reg4_ctrl;

   localparam logic [1:0] OP_LOAD     = 2'b00;
   localparam logic [1:0] OP_SHIFT_IN = 2'b01;
   localparam logic [1:0] OP_ROTATE   = 2'b10;
   localparam logic [1:0] OP_CLEAR    = 2'b11;

   logic       clk = 1'b0;
   logic       reset;
   logic       sr_set;
   logic [3:0] sr_d;
   logic       sr_sin;
   logic [3:0] sr_q = 4'h0;
   logic       so_valid;
   logic       so_bit;
   logic       busy;
   logic       done;
   logic [3:0] result;

   int checks = 0;
   int errors = 0;
   logic [3:0] exp_q[$];
   logic [3:0] mq;

   shift_reg4_ctrl_if cmd_if ();

   shift_reg4_ctrl dut (
      .clk      (clk),
      .reset    (reset),
      .cmd      (cmd_if),
      .sr_set   (sr_set),
      .sr_d     (sr_d),
      .sr_sin   (sr_sin),
      .sr_q     (sr_q),
      .so_valid (so_valid),
      .so_bit   (so_bit),
      .busy     (busy),
      .done     (done),
      .result   (result)
   );

   always #5 clk = ~clk;

   // behavioural shift_reg4
   always @(posedge clk)
      sr_q <= sr_set ? sr_d : {sr_q[2:0], sr_sin};

   task automatic chk(input string tag, input logic [3:0] obs,
                      input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // scoreboard: each done pulse consumes one expected result
   always @(negedge clk) begin
      if (reset === 1'b1 && done === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 4'h1, 4'h0);
         end else begin
            chk("result", result, exp_q.pop_front());
         end
      end
   end

   task automatic issue(input logic [1:0] op, input logic [3:0] data,
                        input logic [1:0] count);
      int n;
      n = 0;
      @(negedge clk);
      while (cmd_if.cmd_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) chk("ready_timeout", 4'h1, 4'h0);
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_op    = op;
      cmd_if.cmd_data  = data;
      cmd_if.cmd_count = count;
      @(posedge clk);
      #1;
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_op    = $urandom_range(3);
      cmd_if.cmd_data  = $urandom_range(15);
      cmd_if.cmd_count = $urandom_range(3);
   endtask

   task automatic do_load(input logic [1:0] op, input logic [3:0] data,
                          input logic [3:0] exp);
      exp_q.push_back(exp);
      issue(op, data, 2'd0);
      @(negedge clk);
      chk("load_ready", {3'b0, cmd_if.cmd_ready}, 4'h0);
      chk("load_set", {3'b0, sr_set}, 4'h1);
      chk("load_d", sr_d, exp);
      @(negedge clk);
      chk("load_q", sr_q, exp);
      chk("load_done", {3'b0, done}, 4'h1);
      @(negedge clk);
      chk("load_done_end", {3'b0, done}, 4'h0);
      chk("load_ready_back", {3'b0, cmd_if.cmd_ready}, 4'h1);
      mq = exp;
   endtask

   task automatic do_shift(input logic [1:0] op, input logic [3:0] data,
                           input logic [1:0] count,
                           input logic [3:0] exp);
      int nc;
      logic sin_e;
      nc = (count == 2'd0) ? 4 : int'(count);
      exp_q.push_back(exp);
      issue(op, data, count);
      for (int k = 0; k < nc; k++) begin
         @(negedge clk);
         sin_e = (op == OP_ROTATE) ? mq[3] : data[k];
         chk("sh_q", sr_q, mq);
         chk("sh_valid", {3'b0, so_valid}, 4'h1);
         chk("sh_bit", {3'b0, so_bit}, {3'b0, mq[3]});
         chk("sh_set", {3'b0, sr_set}, 4'h0);
         chk("sh_sin", {3'b0, sr_sin}, {3'b0, sin_e});
         chk("sh_done", {3'b0, done}, 4'h0);
         mq = {mq[2:0], sin_e};
      end
      @(negedge clk);
      chk("sh_final_q", sr_q, exp);
      chk("sh_done_hi", {3'b0, done}, 4'h1);
      chk("sh_valid_lo", {3'b0, so_valid}, 4'h0);
      @(negedge clk);
      chk("sh_ready_back", {3'b0, cmd_if.cmd_ready}, 4'h1);
      mq = exp;
   endtask

   initial begin
      reset = 1'b0;
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_op    = 2'b00;
      cmd_if.cmd_data  = 4'h0;
      cmd_if.cmd_count = 2'd0;
      mq = 4'h0;
      #1;
      chk("rst_ready", {3'b0, cmd_if.cmd_ready}, 4'h1);
      chk("rst_busy", {3'b0, busy}, 4'h0);
      chk("rst_result", result, 4'h0);
      chk("rst_sin", {3'b0, sr_sin}, 4'h0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("idle_set", {3'b0, sr_set}, 4'h1);
         chk("idle_q", sr_q, 4'h0);
         chk("idle_ready", {3'b0, cmd_if.cmd_ready}, 4'h1);
         chk("idle_done", {3'b0, done}, 4'h0);
         chk("idle_valid", {3'b0, so_valid}, 4'h0);
      end

      do_load(OP_LOAD, 4'hA, 4'hA);
      chk("hold_result", result, 4'hA);
      do_load(OP_CLEAR, 4'h7, 4'h0);
      do_shift(OP_SHIFT_IN, 4'b1011, 2'd0, 4'hD);
      do_load(OP_LOAD, 4'hA, 4'hA);
      do_shift(OP_SHIFT_IN, 4'b0001, 2'd2, 4'hA);
      do_load(OP_LOAD, 4'h9, 4'h9);
      do_shift(OP_ROTATE, 4'h0, 2'd1, 4'h3);
      do_load(OP_CLEAR, 4'hF, 4'h0);
      do_load(OP_LOAD, 4'h5, 4'h5);
      do_shift(OP_ROTATE, 4'h0, 2'd3, 4'hA);

      // abort a 4-cycle shift in its second cycle
      issue(OP_SHIFT_IN, 4'hF, 2'd0);
      @(negedge clk);
      @(negedge clk);
      chk("abort_busy_pre", {3'b0, busy}, 4'h1);
      reset = 1'b0;
      #1;
      chk("abort_busy", {3'b0, busy}, 4'h0);
      chk("abort_result", result, 4'h0);
      chk("abort_done", {3'b0, done}, 4'h0);
      chk("abort_ready", {3'b0, cmd_if.cmd_ready}, 4'h1);
      chk("abort_set", {3'b0, sr_set}, 4'h1);
      @(negedge clk);
      reset = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("post_abort_done", {3'b0, done}, 4'h0);
      end
      do_load(OP_LOAD, 4'h6, 4'h6);

      repeat (2) @(negedge clk);
      chk("sb_empty", exp_q.size() == 0 ? 4'h0 : 4'h1, 4'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
